// File: rtl/oclib_uart.sv
// Full-duplex 8N1 UART: byte stream with valid/ready on both sides to and from
// the serial pins. The receiver resynchronises on every start bit.
module oclib_uart #(
   parameter int ClockHz    = 100000000,
   parameter int Baud       = 115200,
   parameter int SyncCycles = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic       tx,
   input  logic [7:0] txData,
   input  logic       txValid,
   output logic       txReady,
   output logic [7:0] rxData,
   output logic       rxValid,
   input  logic       rxReady,
   output logic       rxFramingError,
   output logic       rxOverflow
);

   localparam int CyclesPerBit = (ClockHz + Baud / 2) / Baud;
   localparam int HalfBit      = CyclesPerBit / 2;
   localparam int CountW       = (CyclesPerBit > 2) ? $clog2(CyclesPerBit) : 1;
   localparam logic [CountW-1:0] BitLoad  = CountW'(CyclesPerBit - 1);
   localparam logic [CountW-1:0] HalfLoad = CountW'(HalfBit - 1);

   if (CyclesPerBit < 8) begin : gBadRate
      $error("oclib_uart: CyclesPerBit must be at least 8");
   end
   if (SyncCycles < 2) begin : gBadSync
      $error("oclib_uart: SyncCycles must be at least 2");
   end

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} txState_t;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rxState_t;

   // ---------------- transmitter ----------------
   txState_t          txState, txStateNext;
   logic [CountW-1:0] txCount, txCountNext;
   logic [7:0]        txShift, txShiftNext;
   logic [2:0]        txBit, txBitNext;
   logic              txNext, txReadyNext, txAccept;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         txState <= TxIdle;
         txCount <= '0;
         txShift <= '0;
         txBit   <= '0;
         tx      <= 1'b1;
         txReady <= 1'b0;
      end else begin
         txState <= txStateNext;
         txCount <= txCountNext;
         txShift <= txShiftNext;
         txBit   <= txBitNext;
         tx      <= txNext;
         txReady <= txReadyNext;
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      txStateNext = txState;
      txCountNext = txCount;
      txShiftNext = txShift;
      txBitNext   = txBit;
      txNext      = tx;
      txReadyNext = txReady;
      txAccept    = txValid && txReady;
      unique case (txState)
         TxIdle: txReadyNext = 1'b1;
         TxStart: begin
            if (txCount == '0) begin
               txStateNext = TxData;
               txCountNext = BitLoad;
               txBitNext   = 3'd0;
               txNext      = txShift[0];
            end else begin
               txCountNext = txCount - CountW'(1);
            end
         end
         TxData: begin
            if (txCount == '0) begin
               txCountNext = BitLoad;
               if (txBit == 3'd7) begin
                  txStateNext = TxStop;
                  txNext      = 1'b1;
               end else begin
                  txBitNext   = txBit + 3'd1;
                  txShiftNext = {1'b0, txShift[7:1]};
                  txNext      = txShift[1];
               end
            end else begin
               txCountNext = txCount - CountW'(1);
            end
         end
         TxStop: begin
            if (txCount == '0) begin
               txStateNext = TxIdle;
            end else begin
               txCountNext = txCount - CountW'(1);
               // Ready during the final stop cycle lets the next start bit follow with no gap.
               if (txCount == CountW'(1)) txReadyNext = 1'b1;
            end
         end
         default: txStateNext = TxIdle;
      endcase
      // txReady is only high in Idle or the last Stop cycle, so acceptance overrides both.
      if (txAccept) begin
         txStateNext = TxStart;
         txCountNext = BitLoad;
         txShiftNext = txData;
         txNext      = 1'b0;
         txReadyNext = 1'b0;
      end
   end

   // ---------------- receiver ----------------
   logic [SyncCycles-1:0] rxSync;
   logic                  rxS;
   rxState_t              rxState, rxStateNext;
   logic [CountW-1:0]     rxCount, rxCountNext;
   logic [7:0]            rxShift, rxShiftNext;
   logic [2:0]            rxBit, rxBitNext;
   logic                  deliver, framing;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) rxSync <= '1;
      else       rxSync <= {rxSync[SyncCycles-2:0], rx};
   end
   assign rxS = rxSync[SyncCycles-1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rxState <= RxIdle;
         rxCount <= '0;
         rxShift <= '0;
         rxBit   <= '0;
      end else begin
         rxState <= rxStateNext;
         rxCount <= rxCountNext;
         rxShift <= rxShiftNext;
         rxBit   <= rxBitNext;
      end
   end

   always_comb begin
      rxStateNext = rxState;
      rxCountNext = rxCount;
      rxShiftNext = rxShift;
      rxBitNext   = rxBit;
      deliver     = 1'b0;
      framing     = 1'b0;
      unique case (rxState)
         RxIdle: begin
            if (!rxS) begin
               rxStateNext = RxStart;
               rxCountNext = HalfLoad;
            end
         end
         RxStart: begin
            if (rxCount == '0) begin
               if (rxS) begin
                  rxStateNext = RxIdle;
               end else begin
                  rxStateNext = RxData;
                  rxCountNext = BitLoad;
                  rxBitNext   = 3'd0;
               end
            end else begin
               rxCountNext = rxCount - CountW'(1);
            end
         end
         RxData: begin
            if (rxCount == '0) begin
               rxShiftNext = {rxS, rxShift[7:1]};
               rxCountNext = BitLoad;
               if (rxBit == 3'd7) rxStateNext = RxStop;
               else               rxBitNext   = rxBit + 3'd1;
            end else begin
               rxCountNext = rxCount - CountW'(1);
            end
         end
         RxStop: begin
            // Leaving at mid-stop gives half a bit of margin for a fast sender.
            if (rxCount == '0) begin
               if (rxS) begin
                  deliver     = 1'b1;
                  rxStateNext = RxIdle;
               end else begin
                  framing     = 1'b1;
                  rxStateNext = RxWaitHigh;
               end
            end else begin
               rxCountNext = rxCount - CountW'(1);
            end
         end
         RxWaitHigh: if (rxS) rxStateNext = RxIdle;
         default:    rxStateNext = RxIdle;
      endcase
   end

   // Single-entry holding register; a full register with no consumer drops the new byte.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rxData         <= '0;
         rxValid        <= 1'b0;
         rxFramingError <= 1'b0;
         rxOverflow     <= 1'b0;
      end else begin
         rxFramingError <= framing;
         rxOverflow     <= 1'b0;
         if (deliver) begin
            if (!rxValid || rxReady) begin
               rxData  <= rxShift;
               rxValid <= 1'b1;
            end else begin
               rxOverflow <= 1'b1;
            end
         end else if (rxValid && rxReady) begin
            rxValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_oclib_uart.sv
// Self-checking bench for oclib_uart: serial line models on both pins, random bytes,
// baud skew, glitch, framing/break, overflow and mid-frame reset.
module tb_oclib_uart;

   // Line rate scaled up so the whole run stays short; all timing derives from it.
   localparam int ClockHz      = 100000000;
   localparam int Baud         = 1000000;
   localparam int CyclesPerBit = (ClockHz + Baud / 2) / Baud;
   localparam int HalfBit      = CyclesPerBit / 2;
   localparam int ClkPeriod    = 10;
   localparam int BitUnits     = CyclesPerBit * ClkPeriod;

   logic       clock, reset, rx, tx;
   logic [7:0] txData, rxData;
   logic       txValid, txReady, rxValid, rxReady, rxFramingError, rxOverflow;

   int checks = 0;
   int errors = 0;

   logic [7:0] txGot[$];
   longint     txStart[$];
   int         txBadStop = 0;
   logic [7:0] rxGot[$];
   int         ferrCount = 0, ovfCount = 0, rxRises = 0;
   logic       rxValidQ = 1'b0;

   oclib_uart #(.ClockHz(ClockHz), .Baud(Baud), .SyncCycles(3)) dut (
      .clock(clock), .reset(reset), .rx(rx), .tx(tx),
      .txData(txData), .txValid(txValid), .txReady(txReady),
      .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
      .rxFramingError(rxFramingError), .rxOverflow(rxOverflow)
   );

   initial clock = 1'b0;
   always #(ClkPeriod / 2) clock = ~clock;

   // Serial receiver model on tx: mid-bit sampling at the nominal rate.
   initial begin : txMonitor
      logic [7:0] b;
      longint     t0;
      forever begin
         @(negedge tx);
         t0 = $time;
         #(BitUnits / 2);
         if (tx !== 1'b0) continue;
         for (int i = 0; i < 8; i++) begin
            #(BitUnits);
            b[i] = tx;
         end
         #(BitUnits);
         if (tx === 1'b1) begin
            txGot.push_back(b);
            txStart.push_back(t0);
         end else begin
            txBadStop++;
         end
      end
   end

   // Consumer side: record handshakes, pulses and rxValid rising edges.
   always @(negedge clock) begin
      if (!reset) begin
         if (rxValid && rxReady) rxGot.push_back(rxData);
         if (rxFramingError) ferrCount++;
         if (rxOverflow) ovfCount++;
         if (rxValid && !rxValidQ) rxRises++;
      end
      rxValidQ = rxValid;
   end

   function automatic int bitUnitsFor(input int baud);
      return int'((longint'(ClkPeriod) * ClockHz + baud / 2) / baud);
   endfunction

   // Serial sender model on rx. With stopBit=0 the line is left low.
   task automatic sendRx(input logic [7:0] b, input int baud, input logic stopBit);
      int d;
      d = bitUnitsFor(baud);
      rx = 1'b0;
      #(d);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(d);
      end
      rx = stopBit;
      #(d);
      if (stopBit) rx = 1'b1;
   endtask

   task automatic pushTx(input logic [7:0] b);
      int n;
      @(negedge clock);
      txData  = b;
      txValid = 1'b1;
      n = 0;
      while (txReady !== 1'b1 && n < 20 * CyclesPerBit) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (txReady !== 1'b1) begin
         errors++;
         $display("FAIL tx_accept_timeout byte %h txReady %b required 1", b, txReady);
         txValid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      txValid = 1'b0;
      txData  = 8'($urandom);
      checks++;
      if (txReady !== 1'b0) begin
         errors++;
         $display("FAIL tx_ready_after_accept got %b required 0", txReady);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clock);
   endtask

   task automatic checkRxBytes(input string name, input int base, input logic [7:0] exp[$]);
      logic [7:0] got;
      checks++;
      if (rxGot.size() !== base + exp.size()) begin
         errors++;
         $display("FAIL %s_count got %0d required %0d", name, rxGot.size() - base, exp.size());
      end
      foreach (exp[i]) begin
         got = (base + i < rxGot.size()) ? rxGot[base + i] : 8'hxx;
         checks++;
         if (got !== exp[i]) begin
            errors++;
            $display("FAIL %s_byte%0d got %h required %h", name, i, got, exp[i]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (10) begin
         @(negedge clock);
         checks++;
         if (tx !== 1'b1 || rxValid !== 1'b0 || txReady !== 1'b0 || rxData !== 8'h00 ||
             rxFramingError !== 1'b0 || rxOverflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got tx=%b rxValid=%b txReady=%b rxData=%h fe=%b ov=%b required 1 0 0 00 0 0",
                     tx, rxValid, txReady, rxData, rxFramingError, rxOverflow);
         end
      end
      reset = 1'b0;
      #1;
      checks++;
      if (txReady !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_early got %b required 0", txReady);
      end
      @(posedge clock);
      #1;
      checks++;
      if (txReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_first_edge got %b required 1", txReady);
      end
   endtask

   task automatic test_tx();
      logic [7:0] exp[$];
      int         base, bad0, n;
      longint     gap;
      exp  = '{8'h55, 8'hA5};
      for (int i = 0; i < 3; i++) exp.push_back(8'($urandom));
      base = txGot.size();
      bad0 = txBadStop;
      foreach (exp[i]) pushTx(exp[i]);
      n = 0;
      while (txGot.size() < base + exp.size() && n < 30 * CyclesPerBit) begin
         @(posedge clock);
         n++;
      end
      checks++;
      if (txGot.size() !== base + exp.size() || txBadStop !== bad0) begin
         errors++;
         $display("FAIL tx_frame_count got %0d bad=%0d required %0d bad=0",
                  txGot.size() - base, txBadStop - bad0, exp.size());
      end
      foreach (exp[i]) begin
         checks++;
         if (base + i >= txGot.size() || txGot[base + i] !== exp[i]) begin
            errors++;
            $display("FAIL tx_byte%0d got %h required %h", i,
                     (base + i < txGot.size()) ? txGot[base + i] : 8'hxx, exp[i]);
         end
         if (i > 0 && base + i < txStart.size()) begin
            gap = (txStart[base + i] - txStart[base + i - 1]) / ClkPeriod;
            checks++;
            if (gap !== longint'(10 * CyclesPerBit)) begin
               errors++;
               $display("FAIL tx_spacing%0d got %0d required %0d", i, gap, 10 * CyclesPerBit);
            end
         end
      end
   endtask

   task automatic test_rx(input int baud);
      logic [7:0] exp[$];
      int         base, f0, o0;
      exp  = '{8'h00, 8'hFF, 8'h3C};
      for (int i = 0; i < 2; i++) exp.push_back(8'($urandom));
      base = rxGot.size();
      f0   = ferrCount;
      o0   = ovfCount;
      rxReady = 1'b1;
      foreach (exp[i]) begin
         sendRx(exp[i], baud, 1'b1);
         #($urandom_range(0, 3) * BitUnits / 2);
      end
      waitCycles(20);
      checkRxBytes($sformatf("rx_%0d", baud), base, exp);
      checks++;
      if (ferrCount !== f0 || ovfCount !== o0) begin
         errors++;
         $display("FAIL rx_%0d_errors got fe=%0d ov=%0d required 0 0", baud, ferrCount - f0, ovfCount - o0);
      end
   endtask

   task automatic test_glitch();
      logic [7:0] exp[$];
      int         base, f0, r0;
      base = rxGot.size();
      f0   = ferrCount;
      r0   = rxRises;
      rx = 1'b0;
      waitCycles(CyclesPerBit / 4);
      rx = 1'b1;
      waitCycles(2 * CyclesPerBit);
      checks++;
      if (rxRises !== r0 || ferrCount !== f0) begin
         errors++;
         $display("FAIL glitch_quiet got rises=%0d fe=%0d required 0 0", rxRises - r0, ferrCount - f0);
      end
      sendRx(8'h81, Baud, 1'b1);
      waitCycles(20);
      exp = '{8'h81};
      checkRxBytes("glitch_next", base, exp);
   endtask

   task automatic test_framing();
      logic [7:0] exp[$];
      int         base, f0, r0;
      base = rxGot.size();
      f0   = ferrCount;
      r0   = rxRises;
      sendRx(8'h12, Baud, 1'b0);
      #(20 * BitUnits);
      rx = 1'b1;
      waitCycles(2 * CyclesPerBit);
      checks++;
      if (ferrCount - f0 !== 1) begin
         errors++;
         $display("FAIL framing_pulse got %0d required 1", ferrCount - f0);
      end
      checks++;
      if (rxRises !== r0) begin
         errors++;
         $display("FAIL framing_no_valid got %0d required 0", rxRises - r0);
      end
      sendRx(8'h34, Baud, 1'b1);
      waitCycles(20);
      exp = '{8'h34};
      checkRxBytes("after_break", base, exp);
   endtask

   task automatic test_overflow_reset();
      int base, o0;
      o0 = ovfCount;
      @(negedge clock);
      rxReady = 1'b0;
      base = rxGot.size();
      sendRx(8'h11, Baud, 1'b1);
      sendRx(8'h22, Baud, 1'b1);
      waitCycles(20);
      checks++;
      if (rxValid !== 1'b1 || rxData !== 8'h11) begin
         errors++;
         $display("FAIL overflow_hold got valid=%b data=%h required 1 11", rxValid, rxData);
      end
      checks++;
      if (ovfCount - o0 !== 1) begin
         errors++;
         $display("FAIL overflow_pulse got %0d required 1", ovfCount - o0);
      end
      @(negedge clock);
      rxReady = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (rxValid !== 1'b0 || rxGot.size() !== base + 1) begin
         errors++;
         $display("FAIL overflow_drain got valid=%b taken=%0d required 0 1", rxValid, rxGot.size() - base);
      end

      base = txGot.size();
      pushTx(8'h77);
      waitCycles(CyclesPerBit / 4);
      #3;
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL reset_tx_in_start got %b required 0", tx);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1 || txReady !== 1'b0 || rxValid !== 1'b0) begin
         errors++;
         $display("FAIL reset_midframe got tx=%b txReady=%b rxValid=%b required 1 0 0", tx, txReady, rxValid);
      end
      waitCycles(5);
      @(negedge clock);
      reset = 1'b0;
      waitCycles(15 * CyclesPerBit);
      checks++;
      if (txGot.size() !== base) begin
         errors++;
         $display("FAIL reset_no_tx_byte got %0d frames required 0", txGot.size() - base);
      end
   endtask

   initial begin : watchdog
      #(longint'(400000) * ClkPeriod);
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      rx      = 1'b1;
      txData  = 8'h00;
      txValid = 1'b0;
      rxReady = 1'b1;
      test_reset();
      test_tx();
      test_rx(Baud);
      test_rx(Baud + Baud / 50);
      test_rx(Baud - Baud / 50);
      test_glitch();
      test_framing();
      test_overflow_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
